// File: rtl/pln_eval.sv
// Postfix ASCII expression evaluator placed after pln_fsm; one character per clock, signed result or error code.
// Optional feature: define PLN_EVAL_DIV_EN to make '/' a signed, truncating divide operator.
module pln_eval #(
   parameter int DATA_W      = 32,
   parameter int STACK_DEPTH = 16
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [7:0]                   DATA_IN,
   output logic [DATA_W-1:0]            RESULT,
   output logic                         RESULT_VLD,
   output logic                         ERR_VLD,
   output logic [2:0]                   ERR_CODE,
   output logic [$clog2(STACK_DEPTH):0] DEPTH
);

   localparam int AW = $clog2(STACK_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(STACK_DEPTH);

   localparam logic [2:0] E_UNDER   = 3'd1;
   localparam logic [2:0] E_OVER    = 3'd2;
   localparam logic [2:0] E_UNBAL   = 3'd3;
   localparam logic [2:0] E_ILLEGAL = 3'd4;
   localparam logic [2:0] E_DIV0    = 3'd5;

   typedef enum logic {S_RUN, S_ERR} state_t;
   typedef enum logic [2:0] {C_IGN, C_DIG, C_OP, C_TERM, C_BAD} cls_t;

   state_t                   state;
   cls_t                     cls;
   logic [DATA_W-1:0]        tos;
   logic [DATA_W-1:0]        mem [STACK_DEPTH];
   logic [AW-1:0]            idx_push;
   logic [AW-1:0]            idx_a;
   logic signed [DATA_W-1:0] op_a;
   logic signed [DATA_W-1:0] op_b;
   logic signed [DATA_W-1:0] op_res;
   logic                     div_zero;
   logic                     push_en;

   // Entries below the top live in mem[0 .. DEPTH-2]; tos holds entry DEPTH-1.
   assign idx_push = DEPTH[AW-1:0] - AW'(1);
   assign idx_a    = DEPTH[AW-1:0] - AW'(2);
   assign op_a     = mem[idx_a];
   assign op_b     = tos;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cls = C_BAD;
      case (DATA_IN)
         8'h00, 8'h20, 8'h0D: cls = C_IGN;
         8'h0A, 8'h3D:        cls = C_TERM;
         8'h2B, 8'h2D, 8'h2A: cls = C_OP;
`ifdef PLN_EVAL_DIV_EN
         8'h2F:               cls = C_OP;
`endif
         default: if (DATA_IN >= 8'h30 && DATA_IN <= 8'h39) cls = C_DIG;
      endcase
   end

   always_comb begin
      op_res   = op_a + op_b;
      div_zero = 1'b0;
      case (DATA_IN)
         8'h2D: op_res = op_a - op_b;
         8'h2A: op_res = op_a * op_b;
`ifdef PLN_EVAL_DIV_EN
         // Divide by -1 is negation so most-negative / -1 wraps instead of trapping.
         8'h2F: begin
            if (op_b == '0)      div_zero = 1'b1;
            else if (op_b == '1) op_res   = -op_a;
            else                 op_res   = op_a / op_b;
         end
`endif
         default: ;
      endcase
   end

   assign push_en = (state == S_RUN) && (cls == C_DIG) && (DEPTH != FULL) && (DEPTH != '0);

   // NOTE: the stack array carries no reset; DEPTH alone defines which entries are live.
   always_ff @(posedge CLK) begin
      if (push_en) mem[idx_push] <= tos;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_RUN;
         tos        <= '0;
         DEPTH      <= '0;
         RESULT     <= '0;
         RESULT_VLD <= 1'b0;
         ERR_VLD    <= 1'b0;
         ERR_CODE   <= 3'd0;
      end else begin
         RESULT_VLD <= 1'b0;
         ERR_VLD    <= 1'b0;
         case (state)
            S_RUN: begin
               case (cls)
                  C_DIG: begin
                     if (DEPTH == FULL) begin
                        ERR_CODE <= E_OVER;
                        state    <= S_ERR;
                     end else begin
                        tos   <= {{(DATA_W-8){1'b0}}, DATA_IN - 8'h30};
                        DEPTH <= DEPTH + (AW+1)'(1);
                     end
                  end
                  C_OP: begin
                     if (DEPTH < (AW+1)'(2)) begin
                        ERR_CODE <= E_UNDER;
                        state    <= S_ERR;
                     end else if (div_zero) begin
                        ERR_CODE <= E_DIV0;
                        state    <= S_ERR;
                     end else begin
                        tos   <= op_res;
                        DEPTH <= DEPTH - (AW+1)'(1);
                     end
                  end
                  C_TERM: begin
                     if (DEPTH == (AW+1)'(1)) begin
                        RESULT     <= tos;
                        RESULT_VLD <= 1'b1;
                        DEPTH      <= '0;
                     end else if (DEPTH != '0) begin
                        ERR_CODE <= E_UNBAL;
                        ERR_VLD  <= 1'b1;
                        DEPTH    <= '0;
                     end
                  end
                  C_BAD: begin
                     ERR_CODE <= E_ILLEGAL;
                     state    <= S_ERR;
                  end
                  default: ;
               endcase
            end
            S_ERR: begin
               if (cls == C_TERM) begin
                  ERR_VLD <= 1'b1;
                  DEPTH   <= '0;
                  state   <= S_RUN;
               end
            end
            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pln_eval.sv
// Self-checking bench for pln_eval: directed vector table, multi-cycle corner sequences,
// and random postfix streams scored against a queue-based model of the evaluation rules.
module tb_pln_eval;

   localparam int DW = 32;
   localparam int SD = 16;
   localparam int AW = 4;
`ifdef PLN_EVAL_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef logic [7:0] bq_t [$];
   typedef struct {
      string       s;
      int          nres;
      int          nerr;
      logic [31:0] res;
      logic [2:0]  code;
   } vec_t;

   logic          CLK = 1'b0;
   logic          RST;
   logic [7:0]    DATA_IN;
   logic [DW-1:0] RESULT;
   logic          RESULT_VLD;
   logic          ERR_VLD;
   logic [2:0]    ERR_CODE;
   logic [AW:0]   DEPTH;

   vec_t        tv [$];
   int          checks = 0;
   int          errors = 0;
   int          mon_nres = 0;
   int          mon_nerr = 0;
   int          both_hi = 0;
   logic [31:0] m_res = 32'd0;
   logic [2:0]  m_code = 3'd0;
   int          m_nres;
   int          m_nerr;

   pln_eval #(.DATA_W(DW), .STACK_DEPTH(SD)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .DATA_IN   (DATA_IN),
      .RESULT    (RESULT),
      .RESULT_VLD(RESULT_VLD),
      .ERR_VLD   (ERR_VLD),
      .ERR_CODE  (ERR_CODE),
      .DEPTH     (DEPTH)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (RESULT_VLD) mon_nres++;
      if (ERR_VLD)    mon_nerr++;
      if (RESULT_VLD && ERR_VLD) both_hi++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input string s, input int nr, input int ne,
                          input logic [31:0] r, input logic [2:0] c);
      vec_t v;
      v.s = s; v.nres = nr; v.nerr = ne; v.res = r; v.code = c;
      tv.push_back(v);
   endtask

   function automatic bq_t str2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   task automatic run_bytes(input bq_t b);
      mon_nres = 0;
      mon_nerr = 0;
      foreach (b[i]) begin
         @(negedge CLK);
         DATA_IN = b[i];
      end
      @(negedge CLK);
      DATA_IN = 8'h00;
      repeat (2) @(negedge CLK);
   endtask

   task automatic check_run(input string name, input int nr, input int ne,
                            input logic [31:0] r, input logic [2:0] c);
      check({name, " result pulses"}, mon_nres, nr);
      check({name, " error pulses"}, mon_nerr, ne);
      check({name, " RESULT"}, RESULT, r);
      if (ne > 0) check({name, " ERR_CODE"}, ERR_CODE, c);
      check({name, " DEPTH"}, DEPTH, 0);
   endtask

   // Reference: evaluate the byte stream on an int queue following the character rules.
   task automatic model_run(input bq_t b);
      int   q [$];
      bit   err;
      bit   term;
      int   a, bb, r;
      logic [7:0] c;
      m_nres = 0;
      m_nerr = 0;
      err = 1'b0;
      foreach (b[i]) begin
         c = b[i];
         term = (c == 8'h0A) || (c == "=");
         if (err) begin
            if (term) begin
               m_nerr++;
               err = 1'b0;
               q.delete();
            end
         end else if (c == 8'h00 || c == 8'h20 || c == 8'h0D) begin
         end else if (c >= "0" && c <= "9") begin
            if (q.size() == SD) begin
               m_code = 3'd2; err = 1'b1;
            end else q.push_back(int'(c) - 48);
         end else if (c == "+" || c == "-" || c == "*" || (DIV_EN && c == "/")) begin
            if (q.size() < 2) begin
               m_code = 3'd1; err = 1'b1;
            end else begin
               bb = q.pop_back();
               a  = q.pop_back();
               if (c == "/" && bb == 0) begin
                  m_code = 3'd5; err = 1'b1;
               end else begin
                  case (c)
                     "+":     r = a + bb;
                     "-":     r = a - bb;
                     "*":     r = a * bb;
                     default: r = (bb == -1) ? -a : a / bb;
                  endcase
                  q.push_back(r);
               end
            end
         end else if (term) begin
            if (q.size() == 1) begin
               m_res = q.pop_back();
               m_nres++;
            end else if (q.size() > 1) begin
               m_code = 3'd3;
               m_nerr++;
               q.delete();
            end
         end else begin
            m_code = 3'd4; err = 1'b1;
         end
      end
   endtask

   initial begin
      bq_t b;
      RST = 1'b1;
      DATA_IN = 8'h00;
      repeat (2) @(negedge CLK);
      check("reset RESULT", RESULT, 0);
      check("reset RESULT_VLD", RESULT_VLD, 0);
      check("reset ERR_VLD", ERR_VLD, 0);
      check("reset ERR_CODE", ERR_CODE, 0);
      check("reset DEPTH", DEPTH, 0);
      RST = 1'b0;
      @(negedge CLK);

      add_vec("34+2*\n",                 1, 0, 32'd14,       3'd0);
      add_vec("92-\n",                   1, 0, 32'd7,        3'd0);
      add_vec("12-\n",                   1, 0, 32'hFFFFFFFF, 3'd0);
      add_vec("99*9*9*9*9*9*9*9*9*\n",   1, 0, 32'hCFD41B91, 3'd0);
      add_vec("+5\n",                    0, 1, 32'hCFD41B91, 3'd1);
      add_vec("5\n",                     1, 0, 32'd5,        3'd0);
      add_vec({"1111111111", "1111111", "\n"}, 0, 1, 32'd5, 3'd2);
      add_vec("123\n",                   0, 1, 32'd5,        3'd3);
      add_vec("3a4+\n",                  0, 1, 32'd5,        3'd4);
`ifdef PLN_EVAL_DIV_EN
      add_vec("82/\n",                   1, 0, 32'd4,        3'd0);
      add_vec("80/\n",                   0, 1, 32'd4,        3'd5);
      add_vec("07-2/\n",                 1, 0, 32'hFFFFFFFD, 3'd0);
`else
      add_vec("82/\n",                   0, 1, 32'd5,        3'd4);
`endif
      add_vec("9\n",                     1, 0, 32'd9,        3'd0);
      add_vec("1+a\n",                   0, 1, 32'd9,        3'd1);
      add_vec("\n",                      0, 0, 32'd9,        3'd0);
      add_vec("5 \r6+=",                 1, 0, 32'd11,       3'd0);
      add_vec("5\n6\n",                  2, 0, 32'd6,        3'd0);
      add_vec("72*4-=\n",                1, 0, 32'd10,       3'd0);

      for (int i = 0; i < tv.size(); i++) begin
         run_bytes(str2q(tv[i].s));
         check_run($sformatf("vec%0d", i), tv[i].nres, tv[i].nerr, tv[i].res, tv[i].code);
      end

      // Pulse timing: result the cycle after the terminator, one cycle wide.
      @(negedge CLK); DATA_IN = "4";
      @(negedge CLK); DATA_IN = 8'h0A;
      check("depth after push", DEPTH, 1);
      @(negedge CLK); DATA_IN = 8'h00;
      check("result pulse high", RESULT_VLD, 1);
      check("result value 4", RESULT, 4);
      check("depth cleared", DEPTH, 0);
      @(negedge CLK);
      check("result pulse low", RESULT_VLD, 0);

      // Error code latches at detection; the pulse waits for the terminator.
      @(negedge CLK); DATA_IN = "x";
      @(negedge CLK); DATA_IN = 8'h0A;
      check("err code latched early", ERR_CODE, 4);
      check("err pulse not yet", ERR_VLD, 0);
      @(negedge CLK); DATA_IN = 8'h00;
      check("err pulse high", ERR_VLD, 1);
      check("no result on err", RESULT_VLD, 0);
      @(negedge CLK);
      check("err pulse low", ERR_VLD, 0);

      // Stack exactly full is legal; the terminator reports it as unbalanced.
      for (int i = 0; i < SD; i++) begin
         @(negedge CLK); DATA_IN = "1";
      end
      @(negedge CLK); DATA_IN = 8'h00;
      check("depth full", DEPTH, SD);
      run_bytes(str2q("\n"));
      check_run("full then term", 0, 1, 32'd4, 3'd3);

      // Asynchronous reset mid-expression.
      @(negedge CLK); DATA_IN = "3";
      @(negedge CLK); DATA_IN = "4";
      @(negedge CLK); DATA_IN = 8'h00;
      check("depth mid expr", DEPTH, 2);
      #2 RST = 1'b1;
      #1;
      check("async rst DEPTH", DEPTH, 0);
      check("async rst RESULT", RESULT, 0);
      check("async rst ERR_CODE", ERR_CODE, 0);
      check("async rst RESULT_VLD", RESULT_VLD, 0);
      check("async rst ERR_VLD", ERR_VLD, 0);
      @(negedge CLK); RST = 1'b0;
      run_bytes(str2q("7\n"));
      check_run("after reset", 1, 0, 32'd7, 3'd0);
      m_res  = 32'd7;
      m_code = 3'd0;

      // Random streams against the model.
      for (int n = 0; n < 200; n++) begin
         int len;
         int r;
         b.delete();
         len = $urandom_range(1, 20);
         for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      b.push_back(8'h30 + 8'($urandom_range(0, 9)));
            else if (r < 80) begin
               case ($urandom_range(0, 3))
                  0: b.push_back("+");
                  1: b.push_back("-");
                  2: b.push_back("*");
                  default: b.push_back("/");
               endcase
            end
            else if (r < 88) b.push_back(8'h20);
            else if (r < 91) b.push_back(8'h0D);
            else if (r < 94) b.push_back(8'h41 + 8'($urandom_range(0, 25)));
            else if (r < 97) b.push_back(8'h00);
            else             b.push_back("=");
         end
         b.push_back(8'h0A);
         model_run(b);
         run_bytes(b);
         check_run($sformatf("rand%0d", n), m_nres, m_nerr, m_res, m_code);
      end

      check("never both pulses", both_hi, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pln_eval.md
Name: pln_eval

Overview:
- Consumer at the far end of the Polish-notation converter. It reads the postfix ASCII byte stream produced by pln_fsm and evaluates it on an internal operand stack.
- Sits directly on pln_fsm's DATA_OUT: one byte per CLK, 8'h00 means "no character this cycle".
- Reports the signed integer result, or an error code, when an expression terminator arrives.

Parameters:
- DATA_W, 32, width of operands, stack entries and RESULT.
- STACK_DEPTH, 16, number of operand stack entries (power of 2, >= 2).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  reset; asynchronous, active-high.
- DATA_IN  in  8  ASCII character from the converter; 8'h00 = idle.
- RESULT  out  DATA_W  signed result of the last good expression; held until the next one.
- RESULT_VLD  out  1  one-cycle pulse; RESULT updated this cycle.
- ERR_VLD  out  1  one-cycle pulse; expression aborted.
- ERR_CODE  out  3  cause, valid with ERR_VLD; held until the next error.
- DEPTH  out  $clog2(STACK_DEPTH)+1  current stack occupancy.

Behaviour:
- Reset (async, RST=1):
  - RESULT=0, RESULT_VLD=0, ERR_VLD=0, ERR_CODE=0, DEPTH=0.
  - FSM goes to S_RUN.
  - Deasserting reset mid-expression discards the partial stack.
- Character handling: one character consumed per CLK, no backpressure. Each character completes in a single cycle.
- FSM states: S_RUN (evaluating) and S_ERR (discarding until terminator).
- S_RUN, per character:
  - 8'h00, 8'h20 (space), 8'h0D: ignored.
  - '0'..'9': push (char-8'h30), zero-extended to DATA_W. If DEPTH==STACK_DEPTH: ERR_CODE=3'd2 (overflow) and go to S_ERR.
  - '+', '-', '*':
    - Requires DEPTH>=2, else ERR_CODE=3'd1 (underflow) and go to S_ERR.
    - Pop b (top), pop a, push (a op b); DEPTH decrements by 1.
    - Arithmetic is two's-complement and truncated to DATA_W; overflow wraps silently.
    - '-' computes a-b.
  - Terminator 8'h0A or '=':
    - DEPTH==1: RESULT<=top, RESULT_VLD=1 next cycle, stack cleared (DEPTH=0).
    - DEPTH==0: nothing happens (blank line).
    - DEPTH>1: ERR_CODE=3'd3 (unbalanced), ERR_VLD=1, stack cleared.
  - Any other byte: ERR_CODE=3'd4 (illegal char), go to S_ERR.
- Error latching: ERR_CODE is latched in the cycle the error is detected. ERR_VLD is not pulsed yet.
- S_ERR:
  - All characters are ignored except a terminator.
  - On a terminator: ERR_VLD pulses one cycle, stack cleared, return to S_RUN.
  - Only the first error of an expression is reported.
- Output timing:
  - RESULT_VLD and ERR_VLD are registered and never both high.
  - Each rises the cycle after the terminator is sampled.
- Back-to-back expressions: a character arriving the cycle after a terminator belongs to the next expression and is evaluated normally.
- Stack implementation: top-of-stack register plus register array. Binary operators read top and top-1 in the same cycle.

Optional Feature:
- Macro: PLN_EVAL_DIV_EN.
- Defined:
  - '/' is a binary operator: signed a/b, truncating toward zero.
  - b==0 gives ERR_CODE=3'd5 (divide by zero) and S_ERR.
  - Most-negative / -1 wraps to the most-negative value.
  - The divider is combinational within the same cycle.
- Undefined: '/' is an illegal character (ERR_CODE=3'd4); no divider logic is generated.

Test Plan:
- Basic operators: "34+2*\n" -> one RESULT_VLD pulse, RESULT=14, DEPTH back to 0. Then "92-\n" -> RESULT=7.
- Signed wrap: "12-\n" -> RESULT=32'hFFFFFFFF. "99*9*9*9*9*9*9*9*9*\n" -> RESULT=3486784401 truncated = 32'hCFD41B91, no error.
- Underflow and recovery: "+5\n" -> ERR_VLD with ERR_CODE=1, no RESULT_VLD, RESULT keeps previous value. Then "5\n" -> RESULT=5.
- Overflow and unbalanced: 17 consecutive '1' then "\n" -> ERR_CODE=2. "123\n" -> ERR_CODE=3, DEPTH=0 afterwards.
- Illegal character and reset: "3a4+\n" -> ERR_CODE=4. Separately, assert RST after "34" (mid-expression) -> DEPTH=0, all outputs 0; then "7\n" -> RESULT=7.
- PLN_EVAL_DIV_EN defined: "82/\n" -> RESULT=4. "80/\n" -> ERR_CODE=5. "07-2/\n" -> RESULT=-3.
